// File: rtl/mul_pkg.sv
// Shared types for the pipelined multiply unit: operation encoding, default
// stage payload and the high-half result selector.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int unsigned MUL_DEF_WIDTH = 32;
  localparam int unsigned MUL_DEF_TAG_W = 5;

  typedef struct packed {
    logic                       valid;
    logic [MUL_DEF_TAG_W-1:0]   tag;
    mul_op_e                    op;
    logic [2*MUL_DEF_WIDTH-1:0] product;
  } mul_stage_t;

  function automatic logic is_high_op(mul_op_e op);
    return op != MUL_OP_MUL;
  endfunction

endpackage

// File: rtl/pipelined_mul_unit_if.sv
// Issue/writeback handshake bundle of the multiply unit, including flush.
interface pipelined_mul_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) ();
  import mul_pkg::*;

  logic               in_valid;
  logic               in_ready;
  mul_op_e            op;
  logic [WIDTH-1:0]   operand1;
  logic [WIDTH-1:0]   operand2;
  logic [TAG_W-1:0]   in_tag;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic [2*WIDTH-1:0] full_product;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output in_valid, op, operand1, operand2, in_tag, flush, out_ready,
    input  in_ready, out_valid, result, full_product, out_tag
  );

  modport slave (
    input  in_valid, op, operand1, operand2, in_tag, flush, out_ready,
    output in_ready, out_valid, result, full_product, out_tag
  );
endinterface

// File: rtl/mul_stage_reg.sv
// One delay stage of the multiply pipeline: enable-gated payload register
// whose valid bit is cleared by flush regardless of the enable.
module mul_stage_reg #(
  parameter type T = mul_pkg::mul_stage_t
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic flush,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else begin
      if (en) q <= d;
      if (flush) q.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipelined_mul_unit.sv
// Handshaked RV M-extension multiplier, STAGES cycles of latency, global stall.
// Optional perf_ops/perf_stalls counters when MUL_PERF_CNT_EN is defined.
module pipelined_mul_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 5,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_mul_unit_if.slave  bus
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_ops,
  output logic [31:0]          perf_stalls
`endif
);
  import mul_pkg::*;

  typedef struct packed {
    logic               valid;
    logic [TAG_W-1:0]   tag;
    mul_op_e            op;
    logic [2*WIDTH-1:0] product;
  } stage_t;

  logic               advance;
  logic               a_sgn;
  logic               b_sgn;
  logic [2*WIDTH-1:0] a_wide;
  logic [2*WIDTH-1:0] b_wide;
  stage_t             s1_d;
  stage_t             s1_q;
  stage_t             pipe [STAGES];
  stage_t             last;

  assign advance     = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;

  // Operands are extended straight to 2*WIDTH: the product modulo 2^(2*WIDTH)
  // equals the (WIDTH+1)-bit signed product truncated to 2*WIDTH bits.
  always_comb begin
    a_sgn  = (bus.op != MUL_OP_MULHU) && bus.operand1[WIDTH-1];
    b_sgn  = ((bus.op == MUL_OP_MUL) || (bus.op == MUL_OP_MULH)) && bus.operand2[WIDTH-1];
    a_wide = {{WIDTH{a_sgn}}, bus.operand1};
    b_wide = {{WIDTH{b_sgn}}, bus.operand2};
    s1_d         = '0;
    s1_d.valid   = bus.in_valid;
    s1_d.tag     = bus.in_tag;
    s1_d.op      = bus.op;
    s1_d.product = a_wide * b_wide;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
    end else begin
      if (advance) s1_q <= s1_d;
      if (bus.flush) s1_q.valid <= 1'b0;
    end
  end

  assign pipe[0] = s1_q;

  for (genvar i = 1; i < STAGES; i++) begin : g_delay
    mul_stage_reg #(.T(stage_t)) u_stage (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .flush (bus.flush),
      .d     (pipe[i-1]),
      .q     (pipe[i])
    );
  end

  assign last             = pipe[STAGES-1];
  assign bus.out_valid    = last.valid;
  assign bus.out_tag      = last.tag;
  assign bus.full_product = last.product;
  assign bus.result       = is_high_op(last.op) ? last.product[2*WIDTH-1:WIDTH]
                                                : last.product[WIDTH-1:0];

`ifdef MUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops    <= '0;
      perf_stalls <= '0;
    end else begin
      if (bus.in_valid && advance) perf_ops <= perf_ops + 32'd1;
      if (bus.out_valid && !bus.out_ready) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule
